multi_monitor: RTL and testbench

MULTI_MONITOR -- requirements
Module: multi_monitor

---
 rtl/multi_monitor_if.sv | 30 +++
 rtl/multi_monitor.sv | 142 ++++++++++++++
 tb/tb_multi_monitor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/multi_monitor_if.sv
// Sample/result bundle for multi_monitor: per-sample request side plus registered result and status side.
interface multi_monitor_if #(
   parameter int NUM_CH = 4
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                  in_valid;
   logic [CHW-1:0]        in_ch;
   logic [11:0]           in_bcd;
   logic                  in_sign;
   logic                  clr;
   logic                  out_valid;
   logic [CHW-1:0]        out_ch;
   logic [1:0]            out_state;
   logic [11:0]           out_delta;
   logic                  out_delta_neg;
   logic [2*NUM_CH-1:0]   ch_state;
   logic [1:0]            worst_state;
   logic                  bcd_err;

   modport master (
      output in_valid, in_ch, in_bcd, in_sign, clr,
      input  out_valid, out_ch, out_state, out_delta, out_delta_neg, ch_state, worst_state, bcd_err
   );

   modport slave (
      input  in_valid, in_ch, in_bcd, in_sign, clr,
      output out_valid, out_ch, out_state, out_delta, out_delta_neg, ch_state, worst_state, bcd_err
   );
endinterface

// File: rtl/multi_monitor.sv
// Per-channel BCD level monitor: classifies each sample, checks step size and sign continuity,
// latches emergencies per channel. Result registered one cycle after the sample, full throughput.
module multi_monitor #(
   parameter int          NUM_CH   = 4,
   parameter logic [11:0] T_BORDER = 12'h400,
   parameter logic [11:0] T_ATTN   = 12'h470,
   parameter logic [11:0] T_EMERG  = 12'h500,
   parameter logic [11:0] T_DELTA  = 12'h050
) (
   input logic           clk,
   input logic           rst,
   multi_monitor_if.slave bus
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [11:0]         last_val [NUM_CH];
   logic [NUM_CH-1:0]   last_sign;
   logic [NUM_CH-1:0]   seen;
   logic [NUM_CH-1:0]   latch;
   logic [2*NUM_CH-1:0] ch_state_q;

   logic                out_valid_q;
   logic [CHW-1:0]      out_ch_q;
   logic [1:0]          out_state_q;
   logic [11:0]         out_delta_q;
   logic                out_delta_neg_q;
   logic                bcd_err_q;

   logic                ch_ok;
   logic                accept;
   logic [11:0]         old_val;
   logic                old_sign;
   logic                old_seen;
   logic                old_latch;
   logic                bad_digit;
   logic                neg;
   logic [11:0]         mag;
   logic [1:0]          level;
   logic                emerg;
   logic [1:0]          new_state;
   logic [1:0]          worst;

   // Digit-wise BCD subtraction; caller guarantees a >= b.
   function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
      logic [11:0] r;
      logic [4:0]  t;
      logic        brw;
      r   = '0;
      brw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, brw};
         if (t[4]) begin
            t   = t + 5'd10;
            brw = 1'b1;
         end else begin
            brw = 1'b0;
         end
         r[4*i +: 4] = t[3:0];
      end
      return r;
   endfunction

   generate
      if ((1 << CHW) == NUM_CH) begin : g_full_range
         assign ch_ok = 1'b1;
      end else begin : g_part_range
         assign ch_ok = (32'(bus.in_ch) < 32'(NUM_CH));
      end
   endgenerate

   assign accept = bus.in_valid && ch_ok;

   always_comb begin
      old_val   = last_val[bus.in_ch];
      old_sign  = last_sign[bus.in_ch];
      old_seen  = seen[bus.in_ch];
      old_latch = latch[bus.in_ch];
      bad_digit = (bus.in_bcd[11:8] > 4'd9) || (bus.in_bcd[7:4] > 4'd9) || (bus.in_bcd[3:0] > 4'd9);
      neg       = old_seen && (bus.in_bcd < old_val);
      mag       = '0;
      if (old_seen)
         mag = neg ? bcd_sub(old_val, bus.in_bcd) : bcd_sub(bus.in_bcd, old_val);
      if (bus.in_bcd >= T_EMERG)       level = 2'd3;
      else if (bus.in_bcd >= T_ATTN)   level = 2'd2;
      else if (bus.in_bcd >= T_BORDER) level = 2'd1;
      else                             level = 2'd0;
      // A clr in the same cycle releases the old latch before this sample is judged.
      emerg = bad_digit || (level == 2'd3) || (old_latch && !bus.clr) ||
              (old_seen && ((mag > T_DELTA) || (bus.in_sign != old_sign)));
      new_state = emerg ? 2'd3 : level;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q     <= 1'b0;
         out_ch_q        <= '0;
         out_state_q     <= '0;
         out_delta_q     <= '0;
         out_delta_neg_q <= 1'b0;
         ch_state_q      <= '0;
         bcd_err_q       <= 1'b0;
         last_sign       <= '0;
         seen            <= '0;
         latch           <= '0;
         for (int k = 0; k < NUM_CH; k++)
            last_val[k] <= '0;
      end else begin
         out_valid_q <= accept;
         if (bus.clr)
            latch <= '0;
         if (accept) begin
            out_ch_q                         <= bus.in_ch;
            out_state_q                      <= new_state;
            out_delta_q                      <= mag;
            out_delta_neg_q                  <= neg;
            last_val[bus.in_ch]              <= bus.in_bcd;
            last_sign[bus.in_ch]             <= bus.in_sign;
            seen[bus.in_ch]                  <= 1'b1;
            latch[bus.in_ch]                 <= emerg;
            ch_state_q[{bus.in_ch, 1'b0} +: 2] <= new_state;
            if (bad_digit)
               bcd_err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      worst = 2'd0;
      for (int k = 0; k < NUM_CH; k++)
         if (ch_state_q[2*k +: 2] > worst)
            worst = ch_state_q[2*k +: 2];
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_ch        = out_ch_q;
   assign bus.out_state     = out_state_q;
   assign bus.out_delta     = out_delta_q;
   assign bus.out_delta_neg = out_delta_neg_q;
   assign bus.ch_state      = ch_state_q;
   assign bus.worst_state   = worst;
   assign bus.bcd_err       = bcd_err_q;
endmodule

// File: tb/tb_multi_monitor.sv
// Bench for multi_monitor: directed scenarios then random samples, all checked against a decimal reference model.
module tb_multi_monitor;
   localparam int NCH = 4;
   localparam int LIM_B = 400, LIM_A = 470, LIM_E = 500, LIM_D = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   multi_monitor_if #(.NUM_CH(NCH)) bus ();
   multi_monitor #(.NUM_CH(NCH)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int       mval   [NCH];
   bit       msign  [NCH];
   bit       mseen  [NCH];
   bit       mlatch [NCH];
   bit       mbad   [NCH];
   bit [1:0] mstate [NCH];
   bit       mbcderr;

   function automatic int bcd2int(input logic [11:0] b);
      return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
   endfunction

   function automatic logic [11:0] int2bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'(v / 100);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit v, input int ch, input logic [11:0] bcd, input bit s, input bit c, input bit r);
      bit       bad, neg, emerg, seen0;
      int       nv, d;
      bit [1:0] lvl, st, worst;
      logic [2*NCH-1:0] cs;
      rst = r; bus.in_valid = v; bus.in_ch = ch[1:0]; bus.in_bcd = bcd; bus.in_sign = s; bus.clr = c;
      @(posedge clk);
      #1;
      rst = 1'b0; bus.in_valid = 1'b0; bus.clr = 1'b0;
      if (r) begin
         for (int i = 0; i < NCH; i++) begin
            mval[i] = 0; msign[i] = 0; mseen[i] = 0; mlatch[i] = 0; mbad[i] = 0; mstate[i] = 0;
         end
         mbcderr = 0;
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_ch", bus.out_ch, 0);
         chk("rst_out_state", bus.out_state, 0);
         chk("rst_out_delta", bus.out_delta, 0);
         chk("rst_out_neg", bus.out_delta_neg, 0);
      end else begin
         if (c)
            for (int i = 0; i < NCH; i++) mlatch[i] = 0;
         if (v) begin
            bad   = (bcd[11:8] > 9) || (bcd[7:4] > 9) || (bcd[3:0] > 9);
            nv    = bcd2int(bcd);
            seen0 = mseen[ch];
            d     = !seen0 ? 0 : (nv >= mval[ch]) ? nv - mval[ch] : mval[ch] - nv;
            neg   = seen0 && (nv < mval[ch]);
            lvl   = (nv >= LIM_E) ? 2'd3 : (nv >= LIM_A) ? 2'd2 : (nv >= LIM_B) ? 2'd1 : 2'd0;
            emerg = bad || lvl == 2'd3 || mlatch[ch] || (seen0 && (d > LIM_D || s != msign[ch]));
            st    = emerg ? 2'd3 : lvl;
            chk("out_valid", bus.out_valid, 1);
            chk("out_ch", bus.out_ch, ch);
            chk("out_state", bus.out_state, st);
            if (!bad && !mbad[ch]) begin
               chk("out_delta", bus.out_delta, int2bcd(d));
               chk("out_delta_neg", bus.out_delta_neg, neg);
            end
            mval[ch] = nv; msign[ch] = s; mseen[ch] = 1; mlatch[ch] = emerg; mbad[ch] = bad;
            mstate[ch] = st;
            if (bad) mbcderr = 1;
         end else begin
            chk("out_valid_idle", bus.out_valid, 0);
         end
      end
      cs = '0; worst = 0;
      for (int i = 0; i < NCH; i++) begin
         cs[2*i +: 2] = mstate[i];
         if (mstate[i] > worst) worst = mstate[i];
      end
      chk("ch_state", bus.ch_state, cs);
      chk("worst_state", bus.worst_state, worst);
      chk("bcd_err", bus.bcd_err, mbcderr);
   endtask

   initial begin
      int ch, nv;
      bit s;
      bus.in_valid = 0; bus.in_ch = 0; bus.in_bcd = 0; bus.in_sign = 0; bus.clr = 0;
      step(0, 0, 12'h000, 0, 0, 1);
      step(1, 2, 12'h555, 0, 0, 1);
      step(0, 0, 12'h000, 0, 0, 0);

      // Level thresholds on ch0, with an intermediate step to keep deltas legal.
      step(1, 0, 12'h399, 0, 0, 0); chk("lvl_399", bus.out_state, 0);
      step(1, 0, 12'h400, 0, 0, 0); chk("lvl_400", bus.out_state, 1);
      step(1, 0, 12'h450, 0, 0, 0);
      step(1, 0, 12'h469, 0, 0, 0); chk("lvl_469", bus.out_state, 1);
      step(1, 0, 12'h470, 0, 0, 0); chk("lvl_470", bus.out_state, 2);
      step(1, 0, 12'h500, 0, 0, 0); chk("lvl_500", bus.out_state, 3);

      // Oversized step latches ch1 until clr.
      step(1, 1, 12'h300, 0, 0, 0);
      step(1, 1, 12'h356, 0, 0, 0);
      chk("step_delta", bus.out_delta, 12'h056); chk("step_state", bus.out_state, 3);
      step(1, 1, 12'h300, 0, 0, 0); chk("latched_state", bus.out_state, 3);
      step(0, 0, 12'h000, 0, 1, 0);
      step(1, 1, 12'h300, 0, 0, 0); chk("after_clr_state", bus.out_state, 0);

      // Exactly T_DELTA downward is legal.
      step(1, 2, 12'h210, 0, 0, 0);
      step(1, 2, 12'h160, 0, 0, 0);
      chk("edge_delta", bus.out_delta, 12'h050); chk("edge_neg", bus.out_delta_neg, 1);
      chk("edge_state", bus.out_state, 0);

      // Sign change on ch3.
      step(1, 3, 12'h100, 0, 0, 0);
      step(1, 3, 12'h100, 1, 0, 0);
      chk("sign_state", bus.out_state, 3); chk("sign_worst", bus.worst_state, 3);

      // Invalid digit, sticky error through clr.
      step(1, 0, 12'h1A0, 0, 0, 0);
      chk("bad_state", bus.out_state, 3); chk("bad_err", bus.bcd_err, 1);
      step(0, 0, 12'h000, 0, 1, 0); chk("bad_err_clr", bus.bcd_err, 1);
      step(0, 0, 12'h000, 0, 0, 1); chk("bad_err_rst", bus.bcd_err, 0);

      // Back-to-back samples with reset landing on the second one.
      step(1, 0, 12'h100, 0, 0, 0); chk("b2b_first", bus.out_valid, 1);
      step(1, 1, 12'h200, 0, 0, 1); chk("b2b_second", bus.out_valid, 0);
      step(1, 0, 12'h300, 0, 0, 1); chk("b2b_third", bus.out_valid, 0);
      step(0, 0, 12'h000, 0, 0, 0);
      chk("b2b_cs", bus.ch_state, 0); chk("b2b_outv", bus.out_valid, 0);

      // Random traffic, mostly small steps around the thresholds.
      for (int n = 0; n < 400; n++) begin
         ch = int'($urandom_range(0, NCH - 1));
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 7))
               0: nv = 399; 1: nv = 400; 2: nv = 469; 3: nv = 470;
               4: nv = 499; 5: nv = 500; 6: nv = 0;   default: nv = 999;
            endcase
         end else begin
            nv = mval[ch] + int'($urandom_range(0, 110)) - 55;
            if (nv < 0) nv = 0;
            if (nv > 999) nv = 999;
         end
         s = msign[ch] ^ ($urandom_range(0, 15) == 0);
         step($urandom_range(0, 3) != 0, ch, int2bcd(nv), s, $urandom_range(0, 9) == 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
